// File: rtl/seq_det_ctrl.sv
`timescale 1ns/1ps
// seq_det_ctrl
// Run-time programmable serial pattern detector with a start/abort run
// controller. The pattern, length, overlap mode, match target and idle timeout
// are loaded through a valid/ready config port while no run is active. During
// a run every qualified serial bit is shifted into a history register and
// compared, together with the bit currently on din, against the pattern.
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   cfg_valid/ready   : config handshake; ready in IDLE and DONE only
//   cfg_pattern       : pattern, bit[len-1] is the first serial bit
//   cfg_len           : pattern length, 0 -> 1, >MAX_LEN -> MAX_LEN
//   cfg_overlap       : 1 = overlapping matches, 0 = fresh bits per match
//   cfg_target        : matches that end a run (0 = unlimited)
//   cfg_timeout       : idle cycles that end a run (0 = disabled)
//   start, abort      : run control
//   din_valid, din    : serial input
//   match             : combinational pulse on the last bit of a match
//   match_cnt         : matches in the current or last run
//   busy/done         : RUN / DONE state decode
//   timed_out         : in DONE, the run ended on the idle timeout
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8,
    parameter int TO_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic [TO_W-1:0]    cfg_timeout,
    input  logic               start,
    input  logic               abort,
    input  logic               din_valid,
    input  logic               din,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done,
    output logic               timed_out
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_e               state_q, state_d;
    logic [MAX_LEN-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 ovl_q, ovl_d;
    logic [CNT_W-1:0]     tgt_q, tgt_d;
    logic [TO_W-1:0]      to_q, to_d;
    logic [MAX_LEN-2:0]   hist_q, hist_d;
    logic [LEN_W-1:0]     fill_q, fill_d;
    logic [TO_W-1:0]      idle_q, idle_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 tout_q, tout_d;

    logic                 cfg_fire;
    logic [LEN_W-1:0]     cfg_len_eff;
    logic [MAX_LEN-1:0]   window;
    logic [MAX_LEN-1:0]   mask;
    logic                 hit;
    logic                 enough;
    logic                 enter_run;
    logic [CNT_W-1:0]     cnt_inc;
    logic [TO_W-1:0]      idle_inc;
    logic [LEN_W-1:0]     fill_inc;

    assign cfg_ready = (state_q != S_RUN);
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign timed_out = (state_q == S_DONE) & tout_q;
    assign match_cnt = cnt_q;
    assign cfg_fire  = cfg_valid & cfg_ready;

    // Length is clamped once at load so the datapath only ever sees 1..MAX_LEN.
    always_comb begin
        cfg_len_eff = cfg_len;
        if (cfg_len == '0)          cfg_len_eff = LEN_ONE;
        else if (cfg_len > LEN_MAX) cfg_len_eff = LEN_MAX;
    end

    // The newest bit sits at window[0]; only the low len bits take part.
    assign window = {hist_q, din};
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) mask[i] = (LEN_W'(i) < len_q);
    end
    assign hit    = ((window ^ pat_q) & mask) == '0;
    assign enough = fill_q >= (len_q - LEN_ONE);
    assign match  = (state_q == S_RUN) & din_valid & ~abort & enough & hit;

    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign idle_inc = (idle_q == '1) ? idle_q : idle_q + TO_W'(1);
    assign fill_inc = (fill_q >= LEN_MAX) ? fill_q : fill_q + LEN_ONE;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        tgt_d     = tgt_q;
        to_d      = to_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        idle_d    = idle_q;
        cnt_d     = cnt_q;
        tout_d    = tout_q;
        enter_run = 1'b0;

        // Latched on the same edge as a start, so the new run sees it.
        if (cfg_fire) begin
            pat_d = cfg_pattern;
            len_d = cfg_len_eff;
            ovl_d = cfg_overlap;
            tgt_d = cfg_target;
            to_d  = cfg_timeout;
        end

        case (state_q)
            S_IDLE: begin
                if (start) enter_run = 1'b1;
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (din_valid) begin
                    hist_d = window[MAX_LEN-2:0];
                    fill_d = fill_inc;
                    idle_d = '0;
                    if (match) begin
                        cnt_d = cnt_inc;
                        if (!ovl_q) fill_d = '0;
                        if ((tgt_q != '0) && (cnt_inc == tgt_q)) state_d = S_DONE;
                    end
                end else begin
                    // A match needs din_valid, a timeout needs !din_valid, so
                    // the target and timeout exits can never collide here.
                    idle_d = idle_inc;
                    if ((to_q != '0) && (idle_inc == to_q)) begin
                        state_d = S_DONE;
                        tout_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (abort)      state_d = S_IDLE;
                else if (start) enter_run = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_run) begin
            state_d = S_RUN;
            cnt_d   = '0;
            hist_d  = '0;
            fill_d  = '0;
            idle_d  = '0;
            tout_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= LEN_ONE;
            ovl_q   <= 1'b1;
            tgt_q   <= '0;
            to_q    <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            idle_q  <= '0;
            cnt_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            tgt_q   <= tgt_d;
            to_q    <= to_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            idle_q  <= idle_d;
            cnt_q   <= cnt_d;
            tout_q  <= tout_d;
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
`timescale 1ns/1ps
// Bench for seq_det_ctrl: a table of vectors for the basic overlapping case,
// hand-written sequences for the multi-cycle corners, then random traffic.
// Every cycle all outputs are compared with a queue-based reference model.
module tb_seq_det_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        cfg_overlap;
    logic [7:0]  cfg_target;
    logic [15:0] cfg_timeout;
    logic        start;
    logic        abort;
    logic        din_valid;
    logic        din;
    logic        match;
    logic [7:0]  match_cnt;
    logic        busy;
    logic        done;
    logic        timed_out;

    always #5 clk = ~clk;

    seq_det_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_target(cfg_target), .cfg_timeout(cfg_timeout),
        .start(start), .abort(abort),
        .din_valid(din_valid), .din(din),
        .match(match), .match_cnt(match_cnt),
        .busy(busy), .done(done), .timed_out(timed_out)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic       last_match;
    logic [7:0] last_cnt;

    // Reference model: run/done flags, config, and the list of bits received
    // since the run started or since the last non-overlapping match.
    bit m_run, m_done, m_tout, m_ovl;
    int m_cnt, m_idle, m_pat, m_len, m_tgt, m_to;
    int mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_done = 0; m_tout = 0; m_cnt = 0; m_idle = 0;
        m_pat = 0; m_len = 1; m_ovl = 1; m_tgt = 0; m_to = 0;
        mq.delete();
    endfunction

    function automatic bit model_match();
        int val, want;
        if (!m_run || din_valid !== 1'b1 || abort === 1'b1) return 0;
        if (mq.size() < m_len - 1) return 0;
        val = int'(din);
        for (int k = 1; k < m_len; k++) val |= mq[mq.size() - k] << k;
        want = m_pat & ((1 << m_len) - 1);
        return val == want;
    endfunction

    function automatic void model_update(input bit em);
        int l;
        if (rst) begin model_reset(); return; end
        if (cfg_valid && !m_run) begin
            l = int'(cfg_len);
            m_pat = int'(cfg_pattern);
            m_len = (l == 0) ? 1 : ((l > 8) ? 8 : l);
            m_ovl = cfg_overlap;
            m_tgt = int'(cfg_target);
            m_to  = int'(cfg_timeout);
        end
        if (m_run) begin
            if (abort) m_run = 0;
            else if (din_valid) begin
                mq.push_back(int'(din));
                if (mq.size() > 8) void'(mq.pop_front());
                m_idle = 0;
                if (em) begin
                    if (m_cnt < 255) m_cnt++;
                    if (!m_ovl) mq.delete();
                    if (m_tgt != 0 && m_cnt == m_tgt) begin m_run = 0; m_done = 1; end
                end
            end else begin
                m_idle++;
                if (m_to != 0 && m_idle == m_to) begin m_run = 0; m_done = 1; m_tout = 1; end
            end
        end else if (m_done && abort) begin
            m_done = 0;
        end else if (start) begin
            m_run = 1; m_done = 0; m_tout = 0; m_cnt = 0; m_idle = 0;
            mq.delete();
        end
    endfunction

    // Inputs are driven at the falling edge; sample, compare, clock the model.
    task automatic tick();
        bit em;
        #1;
        em = model_match();
        last_match = match;
        last_cnt   = match_cnt;
        chk("match", match, em);
        chk("match_cnt", match_cnt, m_cnt);
        chk("busy", busy, m_run);
        chk("done", done, m_done);
        chk("timed_out", timed_out, m_done & m_tout);
        chk("cfg_ready", cfg_ready, !m_run);
        @(posedge clk);
        model_update(em);
        cyc++;
        @(negedge clk);
    endtask

    task automatic clr_inputs();
        rst = 0; cfg_valid = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
        cfg_target = 0; cfg_timeout = 0; start = 0; abort = 0; din_valid = 0; din = 0;
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o,
                          input logic [7:0] t, input logic [15:0] to, input logic st);
        cfg_valid = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        cfg_target = t; cfg_timeout = to; start = st;
        tick();
        cfg_valid = 0; start = 0;
    endtask

    task automatic do_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic do_abort();
        abort = 1; tick(); abort = 0;
    endtask

    task automatic idle_cycles(input int n);
        din_valid = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Sends n bits MSB first; mm[i] records the match pulse on bit i+1.
    task automatic send(input logic [31:0] bits, input int n, output logic [31:0] mm);
        mm = '0;
        for (int i = 0; i < n; i++) begin
            din_valid = 1; din = bits[n-1-i];
            tick();
            mm[i] = last_match;
        end
        din_valid = 0;
    endtask

    typedef struct {
        logic       v;
        logic       d;
        logic       m;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[9];
    logic [31:0] mm;

    initial begin
        // Overlapping 11011 on 11011011: pulses on bits 5 and 8.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 8'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 8'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 8'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 8'd0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'd1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 8'd1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 8'd1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 8'd2};

        clr_inputs();
        model_reset();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        tick();
        rst = 0;
        chk("rst cfg_ready", cfg_ready, 1);
        chk("rst match_cnt", match_cnt, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst timed_out", timed_out, 0);

        // Table: overlapping detection.
        do_cfg(8'b11011, 4'd5, 1'b1, 8'd0, 16'd0, 1'b0);
        do_start();
        for (int i = 0; i < 9; i++) begin
            din_valid = tbl[i].v; din = tbl[i].d;
            tick();
            chk("tbl match", last_match, tbl[i].m);
            chk("tbl cnt", last_cnt, tbl[i].cnt);
        end
        din_valid = 0;

        // Non-overlapping: after bit 5 the window needs five fresh bits,
        // which first line up as 11011 on bits 7..11.
        do_abort();
        do_cfg(8'b11011, 4'd5, 1'b0, 8'd0, 16'd0, 1'b0);
        do_start();
        send(32'b11011011, 8, mm);
        chk("novl mask8", mm, 32'h10);
        chk("novl cnt8", match_cnt, 1);
        send(32'b011011, 6, mm);
        chk("novl mask14", mm, 32'h04);
        chk("novl cnt14", match_cnt, 2);

        // Target of 2 ends the run on bit 8; later bits are ignored.
        do_abort();
        do_cfg(8'b11011, 4'd5, 1'b1, 8'd2, 16'd0, 1'b0);
        do_start();
        send(32'b11011011, 8, mm);
        chk("tgt mask", mm, 32'h90);
        chk("tgt done", done, 1);
        chk("tgt busy", busy, 0);
        chk("tgt cnt", match_cnt, 2);
        send(32'b11011, 5, mm);
        chk("tgt post mask", mm, 0);
        chk("tgt post cnt", match_cnt, 2);

        // Timeout of 4 idle cycles; a 3-cycle gap must not trip it.
        do_cfg(8'b11011, 4'd5, 1'b1, 8'd0, 16'd4, 1'b0);
        do_start();
        send(32'b11, 2, mm);
        idle_cycles(3);
        chk("to busy@3", busy, 1);
        idle_cycles(1);
        chk("to done", done, 1);
        chk("to flag", timed_out, 1);
        chk("to cnt", match_cnt, 0);
        do_start();
        chk("to restart flag", timed_out, 0);
        send(32'b11, 2, mm);
        idle_cycles(3);
        chk("gap busy", busy, 1);
        send(32'b011, 3, mm);
        chk("gap mask", mm, 32'h4);
        chk("gap cnt", match_cnt, 1);

        // Abort on the final bit of a second match suppresses it.
        do_abort();
        chk("abort idle", cfg_ready, 1);
        do_cfg(8'b11011, 4'd5, 1'b1, 8'd0, 16'd0, 1'b0);
        do_start();
        send(32'b11011, 5, mm);
        send(32'b01, 2, mm);
        din_valid = 1; din = 1; abort = 1;
        tick();
        abort = 0; din_valid = 0;
        chk("abort match", last_match, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort cnt", match_cnt, 1);

        // Reset mid-run restores outputs and the default config (len 1, pattern 0).
        do_start();
        send(32'b11011, 5, mm);
        rst = 1; tick(); rst = 0;
        chk("mrst cfg_ready", cfg_ready, 1);
        chk("mrst cnt", match_cnt, 0);
        chk("mrst busy", busy, 0);
        chk("mrst done", done, 0);
        chk("mrst timed_out", timed_out, 0);
        do_start();
        send(32'b10, 2, mm);
        chk("mrst dflt mask", mm, 32'h2);

        // Config and start together in DONE: the new run uses the new pattern.
        do_abort();
        do_cfg(8'b11011, 4'd5, 1'b1, 8'd1, 16'd0, 1'b0);
        do_start();
        send(32'b11011, 5, mm);
        chk("cs done", done, 1);
        do_cfg(8'b101, 4'd3, 1'b1, 8'd0, 16'd0, 1'b1);
        chk("cs busy", busy, 1);
        send(32'b10101, 5, mm);
        chk("cs mask", mm, 32'h14);
        chk("cs cnt", match_cnt, 2);

        // Length clamps: 15 acts as 8, 0 acts as 1.
        do_abort();
        do_cfg(8'hA5, 4'd15, 1'b1, 8'd0, 16'd0, 1'b0);
        do_start();
        send(32'hA5, 8, mm);
        chk("len15 mask", mm, 32'h80);
        do_abort();
        do_cfg(8'h01, 4'd0, 1'b1, 8'd0, 16'd0, 1'b0);
        do_start();
        send(32'b101, 3, mm);
        chk("len0 mask", mm, 32'h5);
        do_abort();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            cfg_valid   = ($urandom_range(0, 7) == 0);
            cfg_pattern = 8'($urandom);
            cfg_len     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(1, 4));
            cfg_overlap = 1'($urandom);
            cfg_target  = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
            cfg_timeout = 16'($urandom_range(0, 6));
            start       = ($urandom_range(0, 9) == 0);
            abort       = ($urandom_range(0, 39) == 0);
            din_valid   = ($urandom_range(0, 2) != 0);
            din         = 1'($urandom);
            tick();
        end
        clr_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
